// File: rtl/contador_mod_param.sv
// contador_mod_param
// Parametrised synchronous modulo-MODULUS up/down counter with enable,
// parallel load (saturating), wrap / one-shot modes and terminal flags.
//
// Parameters:
//   WIDTH    counter width in bits (>= 2)
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   RST_VAL  value loaded on reset, < MODULUS
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous reset, active HIGH despite the name
//   en         count enable
//   up_dn      1 = count up, 0 = count down
//   mode       0 = wrap (free-run), 1 = one-shot (halt at terminal)
//   load       parallel load strobe (overrides en)
//   load_val   value to load; values >= MODULUS saturate to MODULUS-1
//   count      current count
//   tc         combinational terminal flag for the current direction
//   wrap_p     one-cycle pulse in the cycle after a wrap
//   done       sticky one-shot halted flag, cleared by reset or load
//   count_gray Gray-code copy of count (only with CONTADOR_GRAY_OUT_EN)
//
// Optional feature macro: CONTADOR_GRAY_OUT_EN adds the count_gray output.

module contador_mod_param #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_p,
`ifdef CONTADOR_GRAY_OUT_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
    // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    // Clamp a load value into the legal count range.
    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
        if ({1'b0, v} < MOD_W)
            return v;
        else
            return MAX_C;
    endfunction

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;
    logic             wrap_nxt;

    assign tc = up_dn ? (count == MAX_C) : (count == '0);

    always_comb begin
        count_nxt = count;
        done_nxt  = done;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = sat_load(load_val);
            done_nxt  = 1'b0;
        end else if (en && !done) begin
            if (tc) begin
                if (mode) begin
                    // One-shot: park on the terminal value and flag it.
                    done_nxt = 1'b1;
                end else begin
                    count_nxt = up_dn ? '0 : MAX_C;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                // Not terminal, so +/-1 stays inside 0..MODULUS-1.
                count_nxt = up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            count  <= RST_C;
            done   <= 1'b0;
            wrap_p <= 1'b0;
        end else begin
            count  <= count_nxt;
            done   <= done_nxt;
            wrap_p <= wrap_nxt;
        end
    end

`ifdef CONTADOR_GRAY_OUT_EN
    // Registered from the next count so it changes on the same edge as count.
    always_ff @(posedge clk) begin
        if (rstn)
            count_gray <= to_gray(RST_C);
        else
            count_gray <= to_gray(count_nxt);
    end
`endif

endmodule

// File: tb/tb_contador_mod_param.sv
// tb_contador_mod_param
// Two counter instances driven by shared stimulus:
//   u0: WIDTH=3, MODULUS=8,  RST_VAL=0 (power-of-two, Gray single-step checks)
//   u1: WIDTH=4, MODULUS=10, RST_VAL=3 (non-power-of-two)
// Directed sequences followed by randomized cycles, checked against a
// behavioural model per instance. Define CONTADOR_GRAY_OUT_EN to also
// check count_gray.

module tb_contador_mod_param;

    logic       clk = 1'b0;
    logic       rstn, en, up_dn, mode, load;
    logic [3:0] load_val;

    logic [2:0] count0;
    logic       tc0, wrap0, done0;
    logic [3:0] count1;
    logic       tc1, wrap1, done1;
`ifdef CONTADOR_GRAY_OUT_EN
    logic [2:0] gray0;
    logic [3:0] gray1;
`endif

    always #5 clk = ~clk;

    contador_mod_param #(.WIDTH(3), .MODULUS(8), .RST_VAL(0)) u0 (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .mode(mode),
        .load(load), .load_val(load_val[2:0]),
        .count(count0), .tc(tc0), .wrap_p(wrap0),
`ifdef CONTADOR_GRAY_OUT_EN
        .count_gray(gray0),
`endif
        .done(done0)
    );

    contador_mod_param #(.WIDTH(4), .MODULUS(10), .RST_VAL(3)) u1 (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .mode(mode),
        .load(load), .load_val(load_val),
        .count(count1), .tc(tc1), .wrap_p(wrap1),
`ifdef CONTADOR_GRAY_OUT_EN
        .count_gray(gray1),
`endif
        .done(done1)
    );

    int nvec = 0;
    int nerr = 0;

    // Model state per instance
    int m_c0 = 0, m_c1 = 0;
    bit m_d0 = 0, m_d1 = 0;
    bit m_w0 = 0, m_w1 = 0;
    bit mvalid = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Behavioural model: counting is arithmetic modulo m.
    task automatic model_step(input int m, input int rv,
                              input bit r, input bit l, input int lv,
                              input bit e, input bit ud, input bit md,
                              inout int c, inout bit d, inout bit w);
        bit term;
        if (r) begin
            c = rv; d = 0; w = 0;
        end else if (l) begin
            c = (lv < m) ? lv : m - 1;
            d = 0; w = 0;
        end else if (e && !d) begin
            term = ud ? (c == m - 1) : (c == 0);
            if (term && md) begin
                d = 1; w = 0;
            end else begin
                c = (c + (ud ? 1 : m - 1)) % m;
                w = term;
            end
        end else begin
            w = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit l, input int lv,
                         input bit e, input bit ud, input bit md);
        int prev0;
        prev0 = m_c0;
        rstn = r; load = l; load_val = 4'(lv); en = e; up_dn = ud; mode = md;
        #1;
        if (mvalid) begin
            chk("tc0", int'(tc0), int'(ud ? (m_c0 == 7) : (m_c0 == 0)));
            chk("tc1", int'(tc1), int'(ud ? (m_c1 == 9) : (m_c1 == 0)));
        end
        @(posedge clk);
        model_step(8,  0, r, l, lv & 7, e, ud, md, m_c0, m_d0, m_w0);
        model_step(10, 3, r, l, lv,     e, ud, md, m_c1, m_d1, m_w1);
        if (r) mvalid = 1;
        #1;
        if (mvalid) begin
            chk("count0", int'(count0), m_c0);
            chk("wrap0",  int'(wrap0),  int'(m_w0));
            chk("done0",  int'(done0),  int'(m_d0));
            chk("count1", int'(count1), m_c1);
            chk("wrap1",  int'(wrap1),  int'(m_w1));
            chk("done1",  int'(done1),  int'(m_d1));
            chk("range1", int'(count1 < 4'd10), 1);
`ifdef CONTADOR_GRAY_OUT_EN
            chk("gray0", int'(gray0), m_c0 ^ (m_c0 >> 1));
            chk("gray1", int'(gray1), m_c1 ^ (m_c1 >> 1));
            if (!r && !l && prev0 != m_c0)
                chk("gray0_onebit", $countones(gray0 ^ 3'((prev0 ^ (prev0 >> 1)))), 1);
`endif
        end
    endtask

    initial begin
        rstn = 1; en = 0; up_dn = 1; mode = 0; load = 0; load_val = 0;

        // Reset then up-count in wrap mode
        repeat (2) cycle(1, 0, 0, 0, 1, 0);
        repeat (10) cycle(0, 0, 0, 1, 1, 0);

        // Down-count from 0 in wrap mode (u1 goes 9,8,...)
        cycle(0, 1, 0, 0, 0, 0);
        repeat (12) cycle(0, 0, 0, 1, 0, 0);

        // One-shot up from 7, then load 3 releases it
        cycle(0, 1, 7, 0, 1, 1);
        repeat (5) cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 1, 0);            // mode 1->0 keeps the hold
        cycle(0, 0, 0, 1, 0, 0);            // direction change keeps the hold
        cycle(0, 1, 3, 1, 1, 1);

        // Priority and saturation
        cycle(0, 1, 4, 1, 1, 0);
        cycle(0, 1, 12, 0, 1, 0);
        cycle(0, 1, 15, 0, 0, 0);
        cycle(0, 1, 6, 0, 1, 0);
        cycle(1, 1, 6, 1, 1, 0);

        // Direction toggling around 5, then enable dropped
        cycle(0, 1, 5, 0, 1, 0);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 1, 0);

        // Reset while done is set
        cycle(0, 1, 8, 0, 1, 1);
        repeat (3) cycle(0, 0, 0, 1, 1, 1);
        cycle(1, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);

        // Full wrap pass for Gray sequence
        repeat (9) cycle(0, 0, 0, 1, 1, 0);

        // Randomized
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) != 0) ^ (i[7] == 1'b1),
                  ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
